// File: rtl/ssd_bcd_driver.sv
// ssd_bcd_driver
// Converts a 13-bit binary debug value to four BCD digits with a sequential
// double-dabble engine, then scans the digits onto a 4-digit common-anode
// seven-segment display (active-low anodes and segments).
module ssd_bcd_driver #(
    parameter int N            = 13,
    parameter int REFRESH_BITS = 20,
    parameter int BLANK_LZ     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         num_i,
    output logic [3:0]           anode_o,
    output logic [6:0]           seg_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_iter;
    logic [N-1:0]            r_bin;
    logic [15:0]             r_bcd;
    logic [15:0]             r_disp;
    logic [REFRESH_BITS-1:0] r_scan;
    logic                    r_done;
    logic [3:0]              r_anode;
    logic [6:0]              r_seg;

    logic [15:0]             w_bcd_adj;
    logic [1:0]              w_sel;
    logic [3:0]              w_digit;
    logic [3:0]              w_lead_zero;
    logic                    w_blank;
    logic [6:0]              w_seg_next;
    logic                    w_disp_ok;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the shift, so pre-bias it by 3.
    function automatic logic [3:0] dabble(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything above 9 renders blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Per-nibble add-3 correction applied before each shift
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            w_bcd_adj[4*i +: 4] = dabble(r_bcd[4*i +: 4]);
        end
    end

    // Conversion control: IDLE (capture) -> SHIFT x N -> DONE (load display)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_disp  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_iter  <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_iter == 4'(N-1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
                S_DONE: begin
                    r_disp  <= r_bcd;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Conversion datapath: capture/clear in IDLE, adjust-then-shift in SHIFT
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_bin <= num_i;
            r_bcd <= '0;
        end else if (r_state == S_SHIFT) begin
            {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
        end
    end

    // Free-running scan counter; its top two bits pick the active digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Digit selection and leading-zero blanking for the current scan slot
    always_comb begin
        w_sel          = r_scan[REFRESH_BITS-1 -: 2];
        w_digit        = r_disp[{w_sel, 2'b00} +: 4];
        w_lead_zero[3] = (r_disp[15:12] == 4'd0);
        w_lead_zero[2] = w_lead_zero[3] && (r_disp[11:8] == 4'd0);
        w_lead_zero[1] = w_lead_zero[2] && (r_disp[7:4] == 4'd0);
        w_lead_zero[0] = 1'b0;
        w_blank        = (BLANK_LZ != 0) ? w_lead_zero[w_sel] : 1'b0;
        w_seg_next     = w_blank ? 7'b1111111 : seg_pattern(w_digit);
    end

    // Registered display outputs, one cycle behind the scan counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode <= 4'b1111;
            r_seg   <= 7'b1111111;
        end else begin
            r_anode <= ~(4'b0001 << w_sel);
            r_seg   <= w_seg_next;
        end
    end

    // Every nibble held for display must be a decimal digit
    always_comb begin
        w_disp_ok = (r_disp[3:0]   <= 4'd9) && (r_disp[7:4]   <= 4'd9) &&
                    (r_disp[11:8]  <= 4'd9) && (r_disp[15:12] <= 4'd9);
    end

    a_disp_bcd: assert property (@(posedge clk) disable iff (rst) w_disp_ok);

    assign anode_o = r_anode;
    assign seg_o   = r_seg;
    assign done_o  = r_done;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Scoreboard bench for ssd_bcd_driver: two instances (plain and with
// leading-zero blanking) share clock, reset and input value.
module tb_ssd_bcd_driver;

    localparam int RB = 4;

    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [3:0] ANODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [12:0] num_i = 13'd1234;

    logic [3:0] anode0, anode1;
    logic [6:0] seg0, seg1;
    logic       done0, done1;

    int n_chk = 0;
    int n_err = 0;
    int q0[$];
    int q1[$];
    int st_e = 0;
    int exp_dones = 0;
    int n_done0 = 0;
    int n_done1 = 0;

    ssd_bcd_driver #(.N(13), .REFRESH_BITS(RB), .BLANK_LZ(0)) dut_plain (
        .clk(clk), .rst(rst), .num_i(num_i),
        .anode_o(anode0), .seg_o(seg0), .done_o(done0)
    );

    ssd_bcd_driver #(.N(13), .REFRESH_BITS(RB), .BLANK_LZ(1)) dut_blank (
        .clk(clk), .rst(rst), .num_i(num_i),
        .anode_o(anode1), .seg_o(seg1), .done_o(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst %0d] at %0t: got %0h, expected %0h",
                     name, inst, $time, act, exp);
        end
    endtask

    // Expected segment pattern of decimal position pos (0 = ones) of value v
    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blz);
        int pw;
        pw = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
        if (blz && pos > 0 && v < pw) return 7'b1111111;
        return SEG[(v / pw) % 10];
    endfunction

    // Drive inputs for the next rising edge; record the value a capture edge takes
    task automatic step(input logic r, input int v);
        @(negedge clk);
        rst   = r;
        num_i = 13'(v);
        if (r) begin
            st_e = 0;
            q0.delete();
            q1.delete();
        end else begin
            st_e++;
            if ((st_e - 1) % 15 == 0) begin
                q0.push_back(v);
                q1.push_back(v);
            end
        end
    endtask

    // One full conversion period; input switches to v2 from step chg_at on
    task automatic run_conv(input int v, input int chg_at, input int v2);
        for (int c = 0; c < 15; c++) step(1'b0, (c < chg_at) ? v : v2);
        exp_dones++;
    endtask

    // Conversion aborted by a one-cycle reset on edge at+1 of the period
    task automatic conv_rst(input int v, input int at);
        for (int c = 0; c < at; c++) step(1'b0, v);
        step(1'b1, v);
    endtask

    // Monitor: compare every output cycle against the expected display
    initial begin
        int         e;
        int         shown [2];
        logic       r_at;
        logic [3:0] a [2];
        logic [6:0] s [2];
        logic       d [2];
        int         pos;
        e     = 0;
        shown = '{0, 0};
        forever begin
            @(posedge clk);
            r_at = rst;
            #1;
            a = '{anode0, anode1};
            s = '{seg0, seg1};
            d = '{done0, done1};
            if (r_at) begin
                e = 0;
                for (int i = 0; i < 2; i++) begin
                    check("rst_anode", i, 32'(a[i]), 32'(4'b1111));
                    check("rst_seg", i, 32'(s[i]), 32'(7'b1111111));
                    check("rst_done", i, 32'(d[i]), 32'(1'b0));
                    shown[i] = 0;
                end
            end else begin
                e++;
                pos = ((e - 1) % 16) / (1 << (RB - 2));
                for (int i = 0; i < 2; i++) begin
                    check("anode", i, 32'(a[i]), 32'(ANODE[pos]));
                    check("anode_onehot", i, $countones(~a[i]), 1);
                    check("seg", i, 32'(s[i]), 32'(exp_seg(shown[i], pos, i == 1)));
                    check("done", i, 32'(d[i]), 32'(e % 15 == 0));
                    if (d[i]) begin
                        if (i == 0) begin
                            n_done0++;
                            check("queue_nonempty", i, 32'(q0.size() != 0), 1);
                            if (q0.size() != 0) shown[i] = q0.pop_front();
                        end else begin
                            n_done1++;
                            check("queue_nonempty", i, 32'(q1.size() != 0), 1);
                            if (q1.size() != 0) shown[i] = q1.pop_front();
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int v, v2, chg;
        repeat (3) step(1'b1, 1234);
        run_conv(1234, 15, 0);
        run_conv(1234, 15, 0);
        run_conv(8191, 15, 0);
        run_conv(8191, 15, 0);
        run_conv(0, 15, 0);
        run_conv(0, 15, 0);
        run_conv(405, 15, 0);
        run_conv(405, 15, 0);
        run_conv(1234, 5, 5678);
        run_conv(5678, 15, 0);
        run_conv(5678, 15, 0);
        conv_rst(5678, 7);
        run_conv(5678, 15, 0);
        run_conv(1234, 15, 0);
        conv_rst(4321, 14);
        run_conv(9, 15, 0);
        run_conv(42, 15, 0);
        for (int k = 0; k < 30; k++) begin
            v   = int'($urandom_range(0, 8191)) >> $urandom_range(0, 12);
            v2  = int'($urandom_range(0, 8191));
            chg = int'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) conv_rst(v, int'($urandom_range(1, 14)));
            else run_conv(v, chg, v2);
        end
        run_conv(7, 15, 0);
        step(1'b0, 7);
        step(1'b0, 7);
        check("done_count", 0, n_done0, exp_dones);
        check("done_count", 1, n_done1, exp_dones);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
